// File: rtl/ahbl_pkg.sv
// AHB-Lite encodings, violation codes and burst helpers shared by the master checker.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [3:0] VIOL_NONE         = 4'd0;
  localparam logic [3:0] VIOL_APH_UNSTABLE = 4'd1;
  localparam logic [3:0] VIOL_TRANS_CHANGE = 4'd2;
  localparam logic [3:0] VIOL_SEQ_NO_BURST = 4'd3;
  localparam logic [3:0] VIOL_SEQ_ADDR     = 4'd4;
  localparam logic [3:0] VIOL_MISALIGNED   = 4'd5;
  localparam logic [3:0] VIOL_SIZE_ILLEGAL = 4'd6;
  localparam logic [3:0] VIOL_WDATA_UNSTBL = 4'd7;
  localparam logic [3:0] VIOL_BURST_1K     = 4'd8;
  localparam logic [3:0] VIOL_BUSY_SINGLE  = 4'd9;

  // Address-phase control held stable while the slave stalls
  typedef struct packed {
    logic       hwrite;
    logic [2:0] hsize;
    logic [2:0] hburst;
    logic [3:0] hprot;
    logic       hmastlock;
    logic       hexcl;
  } ahbl_ctrl_t;

  // Beats remaining after the NONSEQ of a burst (unbounded INCR reports 0)
  function automatic logic [3:0] burst_len_m1(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
      HBURST_WRAP16, HBURST_INCR16: return 4'd15;
      default:                      return 4'd0;
    endcase
  endfunction

  function automatic logic burst_is_fixed(input logic [2:0] hburst);
    return hburst != HBURST_INCR;
  endfunction

  function automatic logic burst_is_wrap(input logic [2:0] hburst);
    return !hburst[0] && (hburst != HBURST_SINGLE);
  endfunction

  // log2 of the beat count of a wrapping burst
  function automatic logic [2:0] burst_wrap_shift(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4:  return 3'd2;
      HBURST_WRAP8:  return 3'd3;
      HBURST_WRAP16: return 3'd4;
      default:       return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahbl_burst_tracker.sv
// Burst context for the master checker: expected next address, beat count, 1 KiB crossing.
module ahbl_burst_tracker
  import ahbl_pkg::*;
#(
  parameter int unsigned W_ADDR = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hready,
  input  logic [1:0]        htrans,
  input  logic [W_ADDR-1:0] haddr,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  output logic [W_ADDR-1:0] exp_addr,
  output logic              ctx_open,
  output logic [2:0]        ctx_size,
  output logic [2:0]        ctx_burst,
  output logic              last_beat_c,
  output logic              cross_1k_c
);

  logic              open_d;
  logic [2:0]        size_d;
  logic [2:0]        burst_d;
  logic [3:0]        rem_q;
  logic [3:0]        rem_d;
  logic [W_ADDR-1:0] exp_d;

  function automatic logic [W_ADDR-1:0] next_addr(input logic [W_ADDR-1:0] a,
                                                  input logic [2:0]        sz,
                                                  input logic [2:0]        bt);
    logic [W_ADDR-1:0] step;
    logic [W_ADDR-1:0] inc;
    logic [W_ADDR-1:0] mask;
    step = W_ADDR'(1) << sz;
    inc  = a + step;
    mask = (step << burst_wrap_shift(bt)) - W_ADDR'(1);
    if (burst_is_wrap(bt)) return (a & ~mask) | (inc & mask);
    return inc;
  endfunction

  // A fixed burst whose final beat has been accepted accepts no more SEQs
  assign last_beat_c = ctx_open && burst_is_fixed(ctx_burst) && (rem_q == 4'd0);
  // Next incrementing beat would start on a 1 KiB boundary
  assign cross_1k_c  = ctx_open && !last_beat_c && ctx_burst[0] && (exp_addr[9:0] == 10'd0);

  // Context update on accepted address phases
  always_comb begin
    open_d  = ctx_open;
    size_d  = ctx_size;
    burst_d = ctx_burst;
    rem_d   = rem_q;
    exp_d   = exp_addr;
    if (hready) begin
      case (htrans)
        HTRANS_NONSEQ: begin
          open_d  = 1'b1;
          size_d  = hsize;
          burst_d = hburst;
          rem_d   = burst_len_m1(hburst);
          exp_d   = next_addr(haddr, hsize, hburst);
        end
        HTRANS_SEQ: begin
          if (ctx_open && !last_beat_c) begin
            exp_d = next_addr(haddr, ctx_size, ctx_burst);
            if (burst_is_fixed(ctx_burst)) rem_d = rem_q - 4'd1;
          end
        end
        HTRANS_IDLE: open_d = 1'b0;
        default: ;
      endcase
    end
  end

  // Context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx_open  <= 1'b0;
      ctx_size  <= 3'd0;
      ctx_burst <= HBURST_SINGLE;
      rem_q     <= 4'd0;
      exp_addr  <= '0;
    end else begin
      ctx_open  <= open_d;
      ctx_size  <= size_d;
      ctx_burst <= burst_d;
      rem_q     <= rem_d;
      exp_addr  <= exp_d;
    end
  end

endmodule

// File: rtl/ahbl_master_checker.sv
// Passive AHB-Lite master-side protocol monitor: flags violations and counts accepted transfers.
module ahbl_master_checker
  import ahbl_pkg::*;
#(
  parameter int unsigned W_ADDR      = 32,
  parameter int unsigned W_DATA      = 32,
  parameter bit          CHECK_WDATA = 1'b1,
  parameter int unsigned W_COUNT     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hready,
  input  logic               hresp,
  input  logic [W_ADDR-1:0]  haddr,
  input  logic               hwrite,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hsize,
  input  logic [2:0]         hburst,
  input  logic [3:0]         hprot,
  input  logic               hmastlock,
  input  logic               hexcl,
  input  logic [W_DATA-1:0]  hwdata,
  output logic               violation,
  output logic [3:0]         violation_code,
  output logic               sticky_error,
  output logic [3:0]         first_code,
  output logic [W_COUNT-1:0] xfer_count
);

  localparam int unsigned MAX_SIZE = $clog2(W_DATA / 8);

  ahbl_ctrl_t        cur_ctrl;
  ahbl_ctrl_t        cap_ctrl_q;
  logic              aph_held_q;
  logic [W_ADDR-1:0] cap_addr_q;
  logic [1:0]        cap_trans_q;
  logic              dph_active_q;
  logic              dph_write_q;
  logic              wd_held_q;
  logic [W_DATA-1:0] wd_cap_q;

  logic [W_ADDR-1:0] exp_addr;
  logic              ctx_open;
  logic [2:0]        ctx_size;
  logic [2:0]        ctx_burst;
  logic              last_beat_c;
  logic              cross_1k_c;

  logic              err_idle;
  logic              c_aph, c_trans, c_noburst, c_seq, c_misalign;
  logic              c_size, c_wdata, c_1k, c_busy;
  logic [W_ADDR-1:0] size_mask;
  logic [3:0]        code_d;

  ahbl_burst_tracker #(.W_ADDR(W_ADDR)) u_burst (
    .clk         (clk),
    .rst_n       (rst_n),
    .hready      (hready),
    .htrans      (htrans),
    .haddr       (haddr),
    .hsize       (hsize),
    .hburst      (hburst),
    .exp_addr    (exp_addr),
    .ctx_open    (ctx_open),
    .ctx_size    (ctx_size),
    .ctx_burst   (ctx_burst),
    .last_beat_c (last_beat_c),
    .cross_1k_c  (cross_1k_c)
  );

  // Individual rule evaluation on the current sample
  always_comb begin
    cur_ctrl.hwrite    = hwrite;
    cur_ctrl.hsize     = hsize;
    cur_ctrl.hburst    = hburst;
    cur_ctrl.hprot     = hprot;
    cur_ctrl.hmastlock = hmastlock;
    cur_ctrl.hexcl     = hexcl;
    size_mask  = (W_ADDR'(1) << hsize) - W_ADDR'(1);
    // First error-response cycle lets the master cancel its held transfer
    err_idle   = aph_held_q && hresp && !hready && (htrans == HTRANS_IDLE);
    c_aph      = aph_held_q && !err_idle && ((haddr != cap_addr_q) || (cur_ctrl != cap_ctrl_q));
    c_trans    = aph_held_q && !err_idle && (htrans != cap_trans_q);
    c_noburst  = htrans[0] && (!ctx_open || last_beat_c);
    c_seq      = (htrans == HTRANS_SEQ) && ctx_open && !last_beat_c &&
                 ((haddr != exp_addr) || (hsize != ctx_size) || (hburst != ctx_burst));
    c_misalign = htrans[1] && ((haddr & size_mask) != '0);
    c_size     = htrans[1] && (hsize > 3'(MAX_SIZE));
    c_wdata    = CHECK_WDATA && wd_held_q && (hwdata != wd_cap_q);
    c_1k       = (htrans == HTRANS_SEQ) && cross_1k_c;
    c_busy     = (htrans == HTRANS_BUSY) && ((hburst == HBURST_SINGLE) || !ctx_open);
  end

  // Lowest code wins when several rules fire together
  always_comb begin
    code_d = VIOL_NONE;
    if      (c_aph)      code_d = VIOL_APH_UNSTABLE;
    else if (c_trans)    code_d = VIOL_TRANS_CHANGE;
    else if (c_noburst)  code_d = VIOL_SEQ_NO_BURST;
    else if (c_seq)      code_d = VIOL_SEQ_ADDR;
    else if (c_misalign) code_d = VIOL_MISALIGNED;
    else if (c_size)     code_d = VIOL_SIZE_ILLEGAL;
    else if (c_wdata)    code_d = VIOL_WDATA_UNSTBL;
    else if (c_1k)       code_d = VIOL_BURST_1K;
    else if (c_busy)     code_d = VIOL_BUSY_SINGLE;
  end

  // Address-phase and data-phase capture, loaded on the first stalled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aph_held_q   <= 1'b0;
      cap_addr_q   <= '0;
      cap_ctrl_q   <= '0;
      cap_trans_q  <= HTRANS_IDLE;
      dph_active_q <= 1'b0;
      dph_write_q  <= 1'b0;
      wd_held_q    <= 1'b0;
      wd_cap_q     <= '0;
    end else begin
      aph_held_q <= htrans[1] && !hready;
      if (!aph_held_q) begin
        cap_addr_q  <= haddr;
        cap_ctrl_q  <= cur_ctrl;
        cap_trans_q <= htrans;
      end
      if (hready) begin
        dph_active_q <= htrans[1];
        dph_write_q  <= hwrite;
      end
      // Held through the completing cycle so the last stalled beat is also compared
      wd_held_q <= CHECK_WDATA && dph_active_q && dph_write_q && !hready;
      if (!wd_held_q) wd_cap_q <= hwdata;
    end
  end

  // Registered reporting and saturating transfer counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      violation      <= 1'b0;
      violation_code <= VIOL_NONE;
      sticky_error   <= 1'b0;
      first_code     <= VIOL_NONE;
      xfer_count     <= '0;
    end else begin
      violation      <= (code_d != VIOL_NONE);
      violation_code <= code_d;
      if (!sticky_error && (code_d != VIOL_NONE)) begin
        sticky_error <= 1'b1;
        first_code   <= code_d;
      end
      if (hready && htrans[1] && (xfer_count != {W_COUNT{1'b1}}))
        xfer_count <= xfer_count + W_COUNT'(1);
    end
  end

`ifdef FORMAL
  // Each rule as a direct proof obligation on the master
  always @(posedge clk) begin
    if (rst_n) begin
      a_aph:      assert (!c_aph);
      a_trans:    assert (!c_trans);
      a_noburst:  assert (!c_noburst);
      a_seq:      assert (!c_seq);
      a_misalign: assert (!c_misalign);
      a_size:     assert (!c_size);
      a_wdata:    assert (!c_wdata);
      a_1k:       assert (!c_1k);
      a_busy:     assert (!c_busy);
    end
  end
`endif

endmodule
